snap_trig_offset_ctrl: RTL and testbench
========================================

SNAP_TRIG_OFFSET_CTRL -- requirements
Module: snap_trig_offset_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the capture buffer address width; depth is 2^ADDR_W samples.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the sample width.
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port user_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ctrl, input, 32 bits: software control word.
- bit0: arm, acting on its rising edge.
- bit1: trig_sel (0 = external trig, 1 = immediate).
- bit2: stop (used only when SNAP_CIRC_EN is defined).
REQ-006 SHALL have port trig_offset, input, 32 bits: unsigned count of valid samples to skip after the trigger, taken from the trig_offset software register.
REQ-007 SHALL have port din, input, DATA_W bits: sample data.
REQ-008 SHALL have port din_we, input, 1 bit: marks din valid this cycle.
REQ-009 SHALL have port trig, input, 1 bit: external trigger, level-sampled.
REQ-010 SHALL have port bram_addr, output, ADDR_W bits: buffer write address.
REQ-011 SHALL have port bram_data, output, DATA_W bits: buffer write data.
REQ-012 SHALL have port bram_we, output, 1 bit: buffer write strobe.
REQ-013 SHALL have port status, output, 32 bits.
- bit31: done.
- bit30: busy.
- bits[ADDR_W:0]: number of samples written.

Function
REQ-014 SHALL implement states IDLE, WAIT_TRIG, DELAY, CAPTURE and DONE.
REQ-015 SHALL register ctrl[0] and detect its rising edge as arm_pulse.
REQ-016 On arm_pulse in any state: latch trig_offset into off_q, clear the write count and go to WAIT_TRIG on the next cycle.
REQ-017 In WAIT_TRIG, the trigger condition is din_we && (trig || trig_sel).
REQ-018 In WAIT_TRIG on the trigger condition: go to CAPTURE if off_q == 0, otherwise go to DELAY.
REQ-019 When off_q == 0, the triggering sample SHALL be written at address 0.
REQ-020 In DELAY, decrement the delay counter (loaded with off_q) on each din_we; go to CAPTURE on the cycle the counter reaches 0.
REQ-021 In DELAY, the first sample captured SHALL be the (off_q+1)-th valid sample at or after the trigger, the trigger sample being the 1st.
REQ-022 In CAPTURE, each din_we SHALL produce exactly one write: bram_we=1, bram_data=din, bram_addr=count[ADDR_W-1:0], all registered one cycle after the input sample.
REQ-023 In CAPTURE, count increments per write; after write 2^ADDR_W-1, go to DONE.
REQ-024 In DONE, status.done=1 and status count = 2^ADDR_W; DONE holds until the next arm_pulse or reset.
REQ-025 status.busy SHALL be 1 in WAIT_TRIG, DELAY and CAPTURE, and 0 otherwise.
REQ-026 bram_we SHALL be 0 in every state other than CAPTURE.
REQ-027 If arm_pulse and trigger coincide, arm_pulse wins and that trigger is ignored.
REQ-028 trig_offset changes after arm SHALL have no effect until the next arm_pulse.
REQ-029 off_q = 0xFFFFFFFF SHALL be legal and SHALL NOT wrap early.

Reset
REQ-030 On user_rst=1 at a clock edge, the state SHALL become IDLE.
REQ-031 On reset, count=0, off_q=0, bram_we=0, bram_addr=0, bram_data=0, status=0, and the arm edge register=0.
REQ-032 A reset asserted mid-capture SHALL abort the capture with no further writes.
REQ-033 An arm bit already high at reset release SHALL NOT generate an arm_pulse.

Configuration
REQ-034 SHALL support the macro SNAP_CIRC_EN.
REQ-035 With SNAP_CIRC_EN defined, CAPTURE SHALL wrap bram_addr modulo 2^ADDR_W and continue writing instead of going to DONE after 2^ADDR_W writes.
REQ-036 With SNAP_CIRC_EN defined, a rising edge of ctrl[2] in CAPTURE SHALL go to DONE.
REQ-037 With SNAP_CIRC_EN defined, the status count SHALL saturate at 2^ADDR_W, and the last-written address SHALL be reported in status bits[29:16].
REQ-038 Without SNAP_CIRC_EN, ctrl[2] SHALL be ignored and status bits[29:16] SHALL read 0.

Structure
REQ-039 A shared package snap_pkg SHALL hold the state enum, the ctrl bit index constants and the status bit index constants.
REQ-040 One sub-module, snap_edge_det, SHALL perform rising-edge detection; it is instanced for arm and, with SNAP_CIRC_EN defined, for stop.
REQ-041 All other logic SHALL be in one module.

Verification
REQ-042 Arm, trig_sel=1, off=0, din_we=1 every cycle, din=counter starting at 100: addresses 0..2047 hold 100..2147 and done=1.
REQ-043 Arm, external trig pulse on sample 500, off=10, din_we continuous: address 0 holds sample 510.
REQ-044 din_we toggling 1-0, off=3: only valid samples are counted, so address 0 holds the 4th valid sample from the trigger inclusive.
REQ-045 Reset asserted after 37 writes: bram_we=0 the next cycle, status=0 and state IDLE.
REQ-046 Arm re-pulsed during DELAY with a new off=5: count clears and the new offset applies.
REQ-047 With SNAP_CIRC_EN defined, stop asserted after 3000 writes: done=1, status bits[29:16] = 951.

Source files
------------

// File: rtl/snap_pkg.sv
// Shared definitions for the snapshot capture controller: FSM states and
// bit positions inside the ctrl and status software words.
package snap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TRIG,
      ST_DELAY,
      ST_CAPTURE,
      ST_DONE
   } snap_state_t;

   localparam int CTRL_ARM      = 0;
   localparam int CTRL_TRIG_SEL = 1;
   localparam int CTRL_STOP     = 2;

   localparam int STAT_DONE    = 31;
   localparam int STAT_BUSY    = 30;
   localparam int STAT_LAST_LO = 16;
   localparam int STAT_LAST_HI = 29;

endpackage

// File: rtl/snap_edge_det.sv
// Rising-edge detector for software control bits. A level already high when
// reset releases is treated as history, not as a new edge.
module snap_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic d_q;
   logic primed;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q    <= 1'b0;
         primed <= 1'b0;
      end else begin
         d_q    <= d;
         primed <= 1'b1;
      end
   end

   // primed masks the first post-reset cycle so a held bit cannot fire
   assign pulse = d & ~d_q & primed;

endmodule

// File: rtl/snap_trig_offset_ctrl.sv
// Triggered snapshot capture with post-trigger sample offset into a BRAM.
// Optional macro SNAP_CIRC_EN: circular capture ended by a ctrl stop edge.
//
// state        | meaning
// ST_IDLE      | inactive since reset, waiting for an arm edge
// ST_WAIT_TRIG | armed, waiting for a valid sample with trigger
// ST_DELAY     | triggered, skipping off_q valid samples
// ST_CAPTURE   | writing one BRAM word per valid sample
// ST_DONE      | buffer full or stopped, holds until re-armed
module snap_trig_offset_ctrl
   import snap_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       ctrl,
   input  logic [31:0]       trig_offset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_we,
   input  logic              trig,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_data,
   output logic              bram_we,
   output logic [31:0]       status
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LAST  = {1'b0, {ADDR_W{1'b1}}};

   snap_state_t       state, state_nxt;
   logic              arm_pulse;
   logic              stop_pulse;
   logic              trig_cond;
   logic              cap;
   logic [31:0]       off_q;
   logic [31:0]       dly;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] wr_ptr;
   logic              ctrl_unused;

   snap_edge_det u_arm (
      .clk   (user_clk),
      .rst   (user_rst),
      .d     (ctrl[CTRL_ARM]),
      .pulse (arm_pulse)
   );

`ifdef SNAP_CIRC_EN
   localparam bit CIRC = 1'b1;

   snap_edge_det u_stop (
      .clk   (user_clk),
      .rst   (user_rst),
      .d     (ctrl[CTRL_STOP]),
      .pulse (stop_pulse)
   );

   assign ctrl_unused = ^ctrl[31:3];
`else
   localparam bit CIRC = 1'b0;

   assign stop_pulse  = 1'b0;
   assign ctrl_unused = ^ctrl[31:2];
`endif

   assign trig_cond = din_we && (trig || ctrl[CTRL_TRIG_SEL]);

   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      // arm has priority over any trigger or sample seen in the same cycle
      if (arm_pulse) begin
         state_nxt = ST_WAIT_TRIG;
      end else begin
         case (state)
            ST_WAIT_TRIG: begin
               if (trig_cond) begin
                  if (off_q == '0) begin
                     cap       = 1'b1;
                     state_nxt = ST_CAPTURE;
                  end else begin
                     state_nxt = ST_DELAY;
                  end
               end
            end
            ST_DELAY: begin
               if (din_we && (dly == '0)) begin
                  cap       = 1'b1;
                  state_nxt = ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (stop_pulse) begin
                  state_nxt = ST_DONE;
               end else if (din_we) begin
                  cap = 1'b1;
                  if (!CIRC && (count == LAST)) begin
                     state_nxt = ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state     <= ST_IDLE;
         off_q     <= '0;
         dly       <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_data <= '0;
      end else begin
         state   <= state_nxt;
         bram_we <= cap;
         if (arm_pulse) begin
            off_q  <= trig_offset;
            count  <= '0;
            wr_ptr <= '0;
         end else begin
            // the trigger sample itself is the first of the off_q skipped samples
            if ((state == ST_WAIT_TRIG) && trig_cond) begin
               dly <= off_q - 32'd1;
            end else if ((state == ST_DELAY) && din_we && (dly != '0)) begin
               dly <= dly - 32'd1;
            end
            if (cap) begin
               bram_addr <= wr_ptr;
               bram_data <= din;
               wr_ptr    <= wr_ptr + 1'b1;
               if (count != DEPTH) begin
                  count <= count + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      status            = '0;
      status[STAT_DONE] = (state == ST_DONE);
      status[STAT_BUSY] = (state == ST_WAIT_TRIG) || (state == ST_DELAY) ||
                          (state == ST_CAPTURE);
      status[ADDR_W:0]  = count;
      if (CIRC) begin
         status[STAT_LAST_HI:STAT_LAST_LO] = 14'(bram_addr);
      end
   end

endmodule

// File: tb/tb_snap_trig_offset_ctrl.sv
// Scoreboard bench for snap_trig_offset_ctrl: a sample-level model pushes the
// expected BRAM writes, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_snap_trig_offset_ctrl;
   import snap_pkg::*;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 2048;
`ifdef SNAP_CIRC_EN
   localparam bit CIRC = 1'b1;
`else
   localparam bit CIRC = 1'b0;
`endif

   logic              user_clk = 1'b0;
   logic              user_rst;
   logic [31:0]       ctrl;
   logic [31:0]       trig_offset;
   logic [DATA_W-1:0] din;
   logic              din_we;
   logic              trig;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_data;
   logic              bram_we;
   logic [31:0]       status;

   snap_trig_offset_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .user_clk    (user_clk),
      .user_rst    (user_rst),
      .ctrl        (ctrl),
      .trig_offset (trig_offset),
      .din         (din),
      .din_we      (din_we),
      .trig        (trig),
      .bram_addr   (bram_addr),
      .bram_data   (bram_data),
      .bram_we     (bram_we),
      .status      (status)
   );

   always #5 user_clk = ~user_clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t e_wr;
   int  n_chk  = 0;
   int  n_pass = 0;

   bit                m_trig_seen;
   int unsigned       m_skip;
   int unsigned       m_off;
   int                m_ncap;
   int                m_limit;
   logic              m_tsel;
   logic [DATA_W-1:0] m_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
   endtask

   always @(negedge user_clk) begin
      if (bram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("extra_write", 64'd1, 64'd0);
         end else begin
            e_wr = exp_q.pop_front();
            chk("wr_addr", 64'(bram_addr), 64'(e_wr.addr));
            chk("wr_data", bram_data, e_wr.data);
         end
      end
   end

   // one input cycle; the model counts valid samples from the trigger on
   task automatic cyc(input logic we, input logic tr);
      din    = m_data;
      din_we = we;
      trig   = tr;
      if (we) begin
         if (!m_trig_seen && (tr || m_tsel)) begin
            m_trig_seen = 1'b1;
            m_skip      = m_off;
         end
         if (m_trig_seen) begin
            if (m_skip != 0) m_skip--;
            else if (m_ncap < m_limit) begin
               exp_q.push_back('{addr: ADDR_W'(m_ncap % DEPTH), data: m_data});
               m_ncap++;
            end
         end
      end
      m_data++;
      @(posedge user_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0);
   endtask

   task automatic arm(input logic [31:0] off, input logic tsel, input logic we);
      ctrl[CTRL_ARM]      = 1'b1;
      ctrl[CTRL_TRIG_SEL] = tsel;
      trig_offset = off;
      din         = m_data;
      din_we      = we;
      trig        = 1'b0;
      m_trig_seen = 1'b0;
      m_skip      = 0;
      m_ncap      = 0;
      m_off       = off;
      m_tsel      = tsel;
      @(posedge user_clk);
      #1;
      ctrl[CTRL_ARM] = 1'b0;
      din_we         = 1'b0;
   endtask

   initial begin
      user_rst    = 1'b1;
      ctrl        = 32'h1;
      trig_offset = 32'd0;
      din         = '0;
      din_we      = 1'b0;
      trig        = 1'b0;
      m_trig_seen = 1'b0;
      m_tsel      = 1'b0;
      m_off       = 0;
      m_skip      = 0;
      m_ncap      = 0;
      m_limit     = CIRC ? (1 << 30) : DEPTH;
      m_data      = '0;
      repeat (3) @(posedge user_clk);
      #1;
      chk("rst_status", status, 32'h0);
      chk("rst_we", 64'(bram_we), 64'd0);
      chk("rst_addr", 64'(bram_addr), 64'd0);
      chk("rst_data", bram_data, 64'd0);

      // arm held high across reset release must not arm
      user_rst = 1'b0;
      idle(3);
      chk("held_arm", status, 32'h0);
      ctrl[CTRL_ARM] = 1'b0;
      idle(1);

      // immediate trigger, zero offset, full buffer
      arm(32'd0, 1'b1, 1'b0);
      chk("arm_busy", status, 32'h4000_0000);
      m_data = 64'd100;
      repeat (DEPTH) cyc(1'b1, 1'b0);
      chk("full_done", 64'(status[STAT_DONE]), CIRC ? 64'd0 : 64'd1);
      chk("full_busy", 64'(status[STAT_BUSY]), CIRC ? 64'd1 : 64'd0);
      chk("full_cnt", 64'(status[ADDR_W:0]), 64'(DEPTH));
      repeat (5) cyc(1'b1, 1'b0);
      chk("full_hold", 64'(status[STAT_DONE]), CIRC ? 64'd0 : 64'd1);
      idle(2);
      chk("q_empty_full", 64'(exp_q.size()), 64'd0);

      // external trigger on sample 500, offset 10, offset changed after arm
      arm(32'd10, 1'b0, 1'b0);
      chk("rearm_clr", status, 32'h4000_0000);
      trig_offset = 32'd99;
      m_data = '0;
      for (int i = 0; i < 520; i++) cyc(1'b1, i == 500);
      chk("off10_cnt", 64'(status[ADDR_W:0]), 64'(m_ncap));
      chk("off10_busy", 64'(status[STAT_BUSY]), 64'd1);
      idle(2);
      chk("q_empty_off10", 64'(exp_q.size()), 64'd0);

      // toggling din_we, offset 3, trigger on an invalid cycle is ignored
      arm(32'd3, 1'b0, 1'b0);
      m_data = '0;
      for (int i = 0; i < 40; i++) cyc(i % 2 == 0, (i == 7) || (i == 10));
      chk("tog_cnt", 64'(status[ADDR_W:0]), 64'(m_ncap));
      idle(2);
      chk("q_empty_tog", 64'(exp_q.size()), 64'd0);

      // re-arm during DELAY with a new offset
      arm(32'd20, 1'b0, 1'b0);
      chk("delay_arm_clr", status, 32'h4000_0000);
      for (int i = 0; i < 6; i++) cyc(1'b1, i == 2);
      chk("in_delay_cnt", 64'(status[ADDR_W:0]), 64'd0);
      arm(32'd5, 1'b1, 1'b0);
      repeat (12) cyc(1'b1, 1'b0);
      chk("rearm_cnt", 64'(status[ADDR_W:0]), 64'd7);
      idle(2);
      chk("q_empty_rearm", 64'(exp_q.size()), 64'd0);

      // arm coinciding with a triggering sample: arm wins, sample ignored
      arm(32'd0, 1'b1, 1'b1);
      repeat (3) cyc(1'b1, 1'b0);
      chk("coinc_cnt", 64'(status[ADDR_W:0]), 64'd3);
      idle(2);
      chk("q_empty_coinc", 64'(exp_q.size()), 64'd0);

      // reset mid-capture after 37 writes
      arm(32'd0, 1'b1, 1'b0);
      repeat (37) cyc(1'b1, 1'b0);
      chk("pre_rst_cnt", status, 32'h4000_0025);
      user_rst = 1'b1;
      din_we   = 1'b1;
      @(posedge user_clk);
      #1;
      chk("rst_mid_we", 64'(bram_we), 64'd0);
      chk("rst_mid_status", status, 32'h0);
      user_rst = 1'b0;
      repeat (5) begin
         @(posedge user_clk);
         #1;
      end
      din_we = 1'b0;
      chk("post_rst_status", status, 32'h0);
      chk("q_empty_rst", 64'(exp_q.size()), 64'd0);

`ifdef SNAP_CIRC_EN
      // circular capture stopped after 3000 writes
      arm(32'd0, 1'b1, 1'b0);
      m_data = '0;
      repeat (3000) cyc(1'b1, 1'b0);
      ctrl[CTRL_STOP] = 1'b1;
      cyc(1'b0, 1'b0);
      ctrl[CTRL_STOP] = 1'b0;
      chk("circ_done", 64'(status[STAT_DONE]), 64'd1);
      chk("circ_last", 64'(status[STAT_LAST_HI:STAT_LAST_LO]), 64'd951);
      chk("circ_cnt", 64'(status[ADDR_W:0]), 64'(DEPTH));
`else
      // stop bit has no effect in the default build
      arm(32'd0, 1'b1, 1'b0);
      repeat (10) cyc(1'b1, 1'b0);
      ctrl[CTRL_STOP] = 1'b1;
      cyc(1'b0, 1'b0);
      repeat (5) cyc(1'b1, 1'b0);
      ctrl[CTRL_STOP] = 1'b0;
      chk("stop_ign", status, 32'h4000_000F);
`endif
      idle(2);
      chk("q_empty_end", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
